// File: rtl/bcd.sv
// Registered BCD-to-seven-segment decoder with optional hex glyphs and
// common-anode polarity; segments only change on a clock edge.
module bcd #(
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic invalid
);

    localparam logic [6:0] BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [3:0] code;
    logic [6:0] glyph;
    logic [6:0] seg_next;
    logic       inv_next;
    logic [6:0] seg_q;
    logic       inv_q;

    assign code = {A, B, C, D};

    // Bit order is a..g, MSB = a. Unknown codes fall to the default so X/Z
    // on an input propagates to the register instead of being masked.
    always_comb begin
        glyph = 7'bx;
        case (code)
            4'd0:  glyph = 7'b1111110;
            4'd1:  glyph = 7'b0110000;
            4'd2:  glyph = 7'b1101101;
            4'd3:  glyph = 7'b1111001;
            4'd4:  glyph = 7'b0110011;
            4'd5:  glyph = 7'b1011011;
            4'd6:  glyph = 7'b1011111;
            4'd7:  glyph = 7'b1110000;
            4'd8:  glyph = 7'b1111111;
            4'd9:  glyph = 7'b1111011;
            4'd10: glyph = 7'b1110111;
            4'd11: glyph = 7'b0011111;
            4'd12: glyph = 7'b1001110;
            4'd13: glyph = 7'b0111101;
            4'd14: glyph = 7'b1001111;
            4'd15: glyph = 7'b1000111;
            default: glyph = 7'bx;
        endcase
    end

    always_comb begin
        inv_next = (code > 4'd9);
        seg_next = glyph;
        if (HEX_MODE == 0 && code > 4'd9)
            seg_next = 7'b0000000;
        if (ACTIVE_LOW != 0)
            seg_next = ~seg_next;
    end

    // Register holds final pin polarity so reset blanking needs no output logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= BLANK;
            inv_q <= 1'b0;
        end else begin
            seg_q <= seg_next;
            inv_q <= inv_next;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_bcd.sv
// Bench for bcd: all four HEX_MODE/ACTIVE_LOW variants driven in parallel and
// compared against a table-driven reference of the display rules.
module tb_bcd;

    logic clk;
    logic rst_n;
    logic A, B, C, D;
    logic [6:0] seg [4];
    logic       inv [4];

    int vectors;
    int miscompares;

    for (genvar p = 0; p < 4; p++) begin : g_dut
        bcd #(
            .HEX_MODE  (p % 2),
            .ACTIVE_LOW(p / 2)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .A      (A),
            .B      (B),
            .C      (C),
            .D      (D),
            .a      (seg[p][6]),
            .b      (seg[p][5]),
            .c      (seg[p][4]),
            .d      (seg[p][3]),
            .e      (seg[p][2]),
            .f      (seg[p][1]),
            .g      (seg[p][0]),
            .invalid(inv[p])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {invalid, a..g} for a code under a given variant.
    function automatic logic [7:0] ref_out(int n, bit hex, bit al);
        logic [6:0] digits [10];
        logic [6:0] hexg [6];
        logic [6:0] s;
        digits = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                   7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        hexg   = '{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
                   7'b1000111};
        if (n < 10)   s = digits[n];
        else if (hex) s = hexg[n - 10];
        else          s = 7'b0000000;
        if (al) s = ~s;
        return {(n >= 10), s};
    endfunction

    function automatic logic [7:0] ref_reset(bit al);
        return {1'b0, al ? 7'h7F : 7'h00};
    endfunction

    task automatic chk(string tag, int p, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s inst=%0d observed=%b expected=%b", tag, p, obs, exp);
        end
    endtask

    task automatic chk_code(string tag, int n);
        for (int p = 0; p < 4; p++)
            chk(tag, p, {inv[p], seg[p]}, ref_out(n, p[0], p[1]));
    endtask

    task automatic chk_reset(string tag);
        for (int p = 0; p < 4; p++)
            chk(tag, p, {inv[p], seg[p]}, ref_reset(p[1]));
    endtask

    task automatic drive(int n);
        {A, B, C, D} = n[3:0];
    endtask

    // Drive on the falling edge, check just after the following rising edge.
    task automatic apply(string tag, int n);
        @(negedge clk);
        drive(n);
        @(posedge clk);
        #1;
        chk_code(tag, n);
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;

        rst_n = 1'b0;
        drive(8);
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_code("first_after_reset", 8);

        for (int k = 0; k < 16; k++) apply("sweep", k);

        // Input wiggle between edges must not reach the outputs.
        apply("hold_base", 3);
        #2;
        drive(12);
        #1;
        chk_code("between_edges", 3);
        apply("consec_3", 3);
        apply("consec_4", 4);

        // Asynchronous reset mid-cycle while showing 5.
        apply("pre_async", 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        @(posedge clk);
        #1;
        chk_reset("reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;
        apply("after_release_7", 7);

        for (int k = 0; k < 300; k++) begin
            n = int'($urandom_range(0, 15));
            apply("random", n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
